// File: rtl/real_window_avg_pkg.sv
// Shared types and real-number helpers for the windowed real averager.
package real_window_avg_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    FLUSH_WAIT = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  // Nearest integer with ties away from zero, whatever tie mode the cast uses.
  function automatic longint round_away(input real x);
    longint r;
    real    diff;
    r    = longint'(x);
    diff = x - real'(r);
    if (diff == 0.5 && x > 0.0) begin
      r = r + 64'sd1;
    end else if (diff == -0.5 && x < 0.0) begin
      r = r - 64'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Round a double to single precision (nearest-even on the 24-bit mantissa).
  function automatic real round_to_single(input real x);
    logic [63:0] bits;
    logic        up;
    bits = $realtobits(x);
    up   = bits[28] && ((|bits[27:0]) || bits[29]);
    bits = {bits[63:29], 29'd0};
    if (up) begin
      bits = bits + 64'h0000_0000_2000_0000;
    end else begin
      bits = bits;
    end
    return $bitstoreal(bits);
  endfunction

endpackage

// File: rtl/real_round_sat.sv
// Combinational real -> signed OUT_WIDTH conversion with rounding and clamping.
module real_round_sat
  import real_window_avg_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  real                         value,
  output logic signed [OUT_WIDTH-1:0] data,
  output logic                        sat
);

  localparam longint MAX_V = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
  localparam longint MIN_V = -(64'sd1 <<< (OUT_WIDTH - 1));

  longint rounded_s;

  // Round, then clamp into the signed output range.
  always_comb begin
    rounded_s = round_away(value);
    data      = '0;
    sat       = 1'b0;
    if (rounded_s > MAX_V) begin
      data = OUT_WIDTH'(MAX_V);
      sat  = 1'b1;
    end else if (rounded_s < MIN_V) begin
      data = OUT_WIDTH'(MIN_V);
      sat  = 1'b1;
    end else begin
      data = OUT_WIDTH'(rounded_s);
    end
  end

endmodule

// File: rtl/real_window_avg.sv
// Multi-channel windowed averager: real accumulators per channel, flush of
// partial means, and a handshaked output register carrying real and integer means.
module real_window_avg
  import real_window_avg_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int OUT_WIDTH = 16,
  parameter  int CHANNELS  = 4,
  parameter  int WINDOW    = 8,
  parameter  int ACC_SHORT = 0,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CW-1:0]               in_chan,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CW-1:0]               out_chan,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output real                         out_mean,
  output logic [7:0]                  out_count,
  output logic                        out_sat,
  output logic                        busy
);

  state_t                      state_r, state_nx;
  logic [CW-1:0]               idx_r, idx_nx;
  logic [CNT_W-1:0]            cnt_r [CHANNELS];
  real                         acc_r [CHANNELS];
  real                         sum_s [CHANNELS];
  logic [CHANNELS-1:0]         add_s, clr_s;
  real                         sample_s;
  logic                        chan_ok_s, out_free_s, in_ready_s, accept_s, last_s;
  logic                        load_s;
  real                         load_mean_s;
  logic [CW-1:0]               load_chan_s;
  logic [CNT_W-1:0]            load_cnt_s;
  logic signed [OUT_WIDTH-1:0] rs_data_s;
  logic                        rs_sat_s;

  assign sample_s   = real'(in_data);
  assign chan_ok_s  = (int'(in_chan) < CHANNELS);
  assign out_free_s = !out_valid || out_ready;
  assign in_ready_s = (state_r == RUN) && !flush && out_free_s;
  assign in_ready   = in_ready_s;
  assign accept_s   = in_valid && in_ready_s && chan_ok_s;
  assign last_s     = (int'(idx_r) == CHANNELS - 1);

  // Candidate new sum per channel; the single-precision variant rounds every addition.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    if (ACC_SHORT != 0) begin : g_short
      assign sum_s[c] = round_to_single(acc_r[c] + sample_s);
    end else begin : g_long
      assign sum_s[c] = acc_r[c] + sample_s;
    end
  end

  // Accumulator and count storage for all channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_r[c] <= 0.0;
        cnt_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clr_s[c]) begin
          acc_r[c] <= 0.0;
          cnt_r[c] <= '0;
        end else if (add_s[c]) begin
          acc_r[c] <= sum_s[c];
          cnt_r[c] <= cnt_r[c] + 8'd1;
        end else begin
          acc_r[c] <= acc_r[c];
          cnt_r[c] <= cnt_r[c];
        end
      end
    end
  end

  // Next-state, channel update strobes and output-load selection.
  always_comb begin
    state_nx    = state_r;
    idx_nx      = idx_r;
    add_s       = '0;
    clr_s       = '0;
    load_s      = 1'b0;
    load_mean_s = 0.0;
    load_chan_s = '0;
    load_cnt_s  = '0;
    case (state_r)
      RUN: begin
        if (flush) begin
          state_nx = FLUSH;
          idx_nx   = '0;
        end else if (accept_s) begin
          if (cnt_r[in_chan] == CNT_W'(WINDOW - 1)) begin
            clr_s[in_chan] = 1'b1;
            load_s         = 1'b1;
            load_mean_s    = sum_s[in_chan] / real'(WINDOW);
            load_chan_s    = in_chan;
            load_cnt_s     = CNT_W'(WINDOW);
          end else begin
            add_s[in_chan] = 1'b1;
          end
        end else begin
          state_nx = RUN;
        end
      end
      FLUSH: begin
        if (cnt_r[idx_r] != '0 && !out_free_s) begin
          state_nx = FLUSH_WAIT;
        end else begin
          if (cnt_r[idx_r] != '0) begin
            clr_s[idx_r] = 1'b1;
            load_s       = 1'b1;
            load_mean_s  = acc_r[idx_r] / real'(cnt_r[idx_r]);
            load_chan_s  = idx_r;
            load_cnt_s   = cnt_r[idx_r];
          end else begin
            load_s = 1'b0;
          end
          if (last_s) begin
            state_nx = RUN;
          end else begin
            idx_nx = idx_r + 1'b1;
          end
        end
      end
      FLUSH_WAIT: begin
        if (out_free_s) begin
          state_nx = FLUSH;
        end else begin
          state_nx = FLUSH_WAIT;
        end
      end
      default: begin
        state_nx = RUN;
        idx_nx   = '0;
      end
    endcase
  end

  // FSM state, scan index and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      idx_r   <= '0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      busy    <= (state_nx != RUN);
    end
  end

  real_round_sat #(.OUT_WIDTH(OUT_WIDTH)) u_round_sat (
    .value (load_mean_s),
    .data  (rs_data_s),
    .sat   (rs_sat_s)
  );

  // Output register: holds while stalled, consume and reload may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      out_mean  <= 0.0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      out_chan  <= load_chan_s;
      out_data  <= rs_data_s;
      out_mean  <= load_mean_s;
      out_count <= load_cnt_s;
      out_sat   <= rs_sat_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_real_window_avg.sv
// Directed bench for real_window_avg: four parameterisations, hand-computed means.
module tb_real_window_avg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks_n = 0;
  int   errors_n = 0;

  // Group A/B: WIDTH 16, window 8; B differs only in OUT_WIDTH=4.
  logic               va, fa, ra;
  logic [1:0]         ca;
  logic signed [15:0] da;
  logic               a_rdy, a_val, a_sat, a_busy, b_rdy, b_val, b_sat, b_busy;
  logic [1:0]         a_chan, b_chan;
  logic signed [15:0] a_data;
  logic signed [3:0]  b_data;
  real                a_mean, b_mean;
  logic [7:0]         a_cnt, b_cnt;

  // Group C/D: WIDTH 32, window 2; C single-precision, D double.
  logic               vc, fc, rc;
  logic [1:0]         cc;
  logic signed [31:0] dc;
  logic               c_rdy, c_val, c_sat, c_busy, d_rdy, d_val, d_sat, d_busy;
  logic [1:0]         c_chan, d_chan;
  logic signed [15:0] c_data, d_data;
  real                c_mean, d_mean;
  logic [7:0]         c_cnt, d_cnt;

  real_window_avg dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(a_rdy), .in_chan(ca), .in_data(da),
    .flush(fa), .out_valid(a_val), .out_ready(ra), .out_chan(a_chan), .out_data(a_data),
    .out_mean(a_mean), .out_count(a_cnt), .out_sat(a_sat), .busy(a_busy));

  real_window_avg #(.OUT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(b_rdy), .in_chan(ca), .in_data(da),
    .flush(fa), .out_valid(b_val), .out_ready(ra), .out_chan(b_chan), .out_data(b_data),
    .out_mean(b_mean), .out_count(b_cnt), .out_sat(b_sat), .busy(b_busy));

  real_window_avg #(.WIDTH(32), .WINDOW(2), .ACC_SHORT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_ready(c_rdy), .in_chan(cc), .in_data(dc),
    .flush(fc), .out_valid(c_val), .out_ready(rc), .out_chan(c_chan), .out_data(c_data),
    .out_mean(c_mean), .out_count(c_cnt), .out_sat(c_sat), .busy(c_busy));

  real_window_avg #(.WIDTH(32), .WINDOW(2), .ACC_SHORT(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_ready(d_rdy), .in_chan(cc), .in_data(dc),
    .flush(fc), .out_valid(d_val), .out_ready(rc), .out_chan(d_chan), .out_data(d_data),
    .out_mean(d_mean), .out_count(d_cnt), .out_sat(d_sat), .busy(d_busy));

  task automatic check(input string tag, input real obs, input real exp);
    checks_n++;
    if (obs != exp) begin
      errors_n++;
      $display("FAIL %s got %f want %f", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic signed [15:0] d);
    va = 1'b1;
    ca = c;
    da = d;
    tick();
    va = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; va = 1'b0; fa = 1'b0; ra = 1'b1; ca = 2'd0; da = 16'sd0;
    vc = 1'b0; fc = 1'b0; rc = 1'b1; cc = 2'd0; dc = 32'sd0;
    #12;
    check("rst_in_ready", a_rdy, 1.0);
    check("rst_out_valid", a_val, 0.0);
    check("rst_out_chan", a_chan, 0.0);
    check("rst_out_data", a_data, 0.0);
    check("rst_out_mean", a_mean, 0.0);
    check("rst_out_count", a_cnt, 0.0);
    check("rst_out_sat", a_sat, 0.0);
    check("rst_busy", a_busy, 0.0);
    rst_n = 1'b1;
    tick();

    // Channel 0, samples 1..8: mean 4.5 rounds to 5.
    for (int i = 1; i <= 7; i++) send(2'd0, 16'(i));
    check("w1_pending", a_val, 0.0);
    send(2'd0, 16'sd8);
    check("w1_valid", a_val, 1.0);
    check("w1_mean", a_mean, 4.5);
    check("w1_data", a_data, 5.0);
    check("w1_count", a_cnt, 8.0);
    check("w1_sat", a_sat, 0.0);
    check("w1_chan", a_chan, 0.0);
    check("w1_b_data", b_data, 5.0);

    // Channel 2, -1/-2 pairs: mean -1.5 rounds to -2.
    for (int i = 0; i < 4; i++) begin
      send(2'd2, -16'sd1);
      send(2'd2, -16'sd2);
    end
    check("w2_mean", a_mean, -1.5);
    check("w2_data", a_data, -2.0);
    check("w2_chan", a_chan, 2.0);

    // Single -3 then flush: partial mean of one sample.
    send(2'd2, -16'sd3);
    fa = 1'b1;
    tick();
    fa = 1'b0;
    check("f1_busy", a_busy, 1.0);
    check("f1_in_ready", a_rdy, 0.0);
    for (int k = 0; k < 10 && !a_val; k++) tick();
    check("f1_valid", a_val, 1.0);
    check("f1_mean", a_mean, -3.0);
    check("f1_data", a_data, -3.0);
    check("f1_count", a_cnt, 1.0);
    check("f1_chan", a_chan, 2.0);
    for (int k = 0; k < 10 && a_busy; k++) tick();
    check("f1_busy_end", a_busy, 0.0);
    check("f1_ready_back", a_rdy, 1.0);

    // Saturation on the 4-bit instance.
    for (int i = 0; i < 8; i++) send(2'd0, 16'sd100);
    check("s1_a_data", a_data, 100.0);
    check("s1_a_sat", a_sat, 0.0);
    check("s1_b_data", b_data, 7.0);
    check("s1_b_sat", b_sat, 1.0);
    check("s1_b_mean", b_mean, 100.0);
    for (int i = 0; i < 8; i++) send(2'd0, -16'sd100);
    check("s2_a_data", a_data, -100.0);
    check("s2_b_data", b_data, -8.0);
    check("s2_b_sat", b_sat, 1.0);

    // Interleaved partial windows, flush under back-pressure; same-cycle sample loses.
    send(2'd1, 16'sd10); send(2'd3, 16'sd7); send(2'd1, 16'sd10); send(2'd3, 16'sd7);
    send(2'd1, 16'sd10); send(2'd3, 16'sd7); send(2'd3, 16'sd7); send(2'd3, 16'sd7);
    ra = 1'b0; fa = 1'b1; va = 1'b1; ca = 2'd0; da = 16'sd50;
    tick();
    fa = 1'b0; va = 1'b0;
    check("f2_busy", a_busy, 1.0);
    check("f2_in_ready", a_rdy, 0.0);
    tick(); tick(); tick();
    check("f2_r1_valid", a_val, 1.0);
    check("f2_r1_chan", a_chan, 1.0);
    check("f2_r1_mean", a_mean, 10.0);
    check("f2_r1_count", a_cnt, 3.0);
    check("f2_stall_busy", a_busy, 1.0);
    check("f2_stall_ready", a_rdy, 0.0);
    ra = 1'b1;
    tick();
    check("f2_r2_valid", a_val, 1.0);
    check("f2_r2_chan", a_chan, 3.0);
    check("f2_r2_mean", a_mean, 7.0);
    check("f2_r2_count", a_cnt, 5.0);
    check("f2_busy_end", a_busy, 0.0);
    tick();
    check("f2_drained", a_val, 0.0);

    // Reset mid-window discards the partial sum.
    for (int i = 0; i < 5; i++) send(2'd0, 16'sd40);
    rst_n = 1'b0;
    #2;
    check("r_out_count", a_cnt, 0.0);
    check("r_out_chan", a_chan, 0.0);
    check("r_out_mean", a_mean, 0.0);
    check("r_out_data", a_data, 0.0);
    check("r_in_ready", a_rdy, 1.0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(2'd0, 16'sd2);
    check("r_post_data", a_data, 2.0);
    check("r_post_mean", a_mean, 2.0);
    check("r_post_count", a_cnt, 8.0);

    // Single vs double precision accumulation of 2^24+1.
    vc = 1'b1; dc = 32'sd16777217;
    tick();
    dc = 32'sd0;
    tick();
    vc = 1'b0;
    check("p_short_valid", c_val, 1.0);
    check("p_short_mean", c_mean, 8388608.0);
    check("p_real_mean", d_mean, 8388608.5);
    check("p_real_data", d_data, 32767.0);
    check("p_real_sat", d_sat, 1.0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
